shift: RTL and testbench
========================

# shift

Parameterizable shift register with load, synchronous set/clear, optional-asynchronous set/clear and serial in/out. It is a general-purpose datapath primitive for serializers, deserializers and delay chains. It has a single clock domain and a synchronous active-low reset.

## Interface
Parameters:
- SHIFT_WIDTH, 4: register width W; W ≥ 2.
- SHIFT_DIRECTION, "LEFT": "LEFT" or "RIGHT". Any other string is an elaboration error.
- LOAD_AVALUE, 11: value loaded by aset. Truncated to W bits.
- LOAD_SVALUE, 14: value loaded by sset. Truncated to W bits.

Ports (clock and reset first):
- clk  input  1  sole clock; rising-edge active.
- rst_n  input  1  synchronous, active-low reset; clears q at the rising clk edge.
- aclr  input  1  active-high clear; forces q = 0.
- aset  input  1  active-high set; forces q = LOAD_AVALUE.
- sclr  input  1  synchronous active-high clear.
- sset  input  1  synchronous active-high set.
- load  input  1  synchronous parallel load of data.
- data  input  W  parallel load value.
- en  input  1  shift enable.
- shiftin  input  1  serial input bit.
- q  output  W  register contents.
- shiftout  output  1  serial output bit.

Port declaration order: sclr, sset, shiftin, load, data, clk, en, aclr, aset, shiftout, q, rst_n.

## Operation
Priority, highest first:
1. aclr: q = 0.
2. aset: q = LOAD_AVALUE.
3. !rst_n: q = 0.
4. sclr: q = 0.
5. sset: q = LOAD_SVALUE.
6. load: q = data.
7. en: shift one position.
8. Otherwise: hold.

Rules:
- sclr, sset and load act regardless of en. en gates only shifting.
- LEFT shift: q = {q[W-2:0], shiftin}.
- RIGHT shift: q = {shiftin, q[W-1:1]}.
- shiftout is combinational from q: q[W-1] when LEFT, q[0] when RIGHT.
- Simultaneous controls resolve strictly by the priority list. Example: aclr and aset both high gives q = 0.
- Reset value of q is 0. shiftout follows q, so it is 0 after any clear.
- No internal state other than q.

## Timing
- Synchronous actions (rst_n, sclr, sset, load, shift) update q at the rising clk edge where they are sampled. Latency is 1 cycle.
- aclr/aset with SHIFT_ASYNC_CTRL_EN defined: take effect immediately, without waiting for clk.
  - q holds the forced value for as long as the control is asserted.
  - After deassertion, the next rising edge resumes normal priority.
- aclr/aset without the macro: sampled at the rising edge with the same 1-cycle latency.
- shiftout changes in the same delta as q. There is no added register stage.
- No handshake; all inputs are sampled every cycle.
- rst_n asserted mid-shift: q = 0 at that edge, and the shift is discarded.

## Configuration
- Macro SHIFT_ASYNC_CTRL_EN.
- Defined: aclr/aset are true asynchronous controls in the register sensitivity.
- Undefined: aclr/aset are synchronous, top priority at the clk edge. The design is then fully synchronous.
- Port list is identical in both builds.

## Structure
- Package shift_pkg holds:
  - direction string constants "LEFT" and "RIGHT";
  - a function that truncates load values to W bits.
- Single module. No sub-module is required; the next-state mux and the register stay inline.

## Test plan
All scenarios use W = 4, LEFT, AVALUE = 11, SVALUE = 14 unless stated.
- aclr=1 with the macro defined, clk running or stopped -> q=0000 immediately, shiftout=0. aclr=1 together with aset=1 -> q=0000.
- aclr=0, aset=1 -> q=1011, shiftout=1. Release aset, then sclr=1 -> q=0000 at the next edge. Then sset=1 -> q=1110 at the next edge.
- en=0, load=1, data=0101 -> q=0101 after one edge. data changes every cycle -> q tracks data with 1-cycle lag.
- q=1011, en=1, shiftin=0 -> q=0110 and shiftout=0. In the RIGHT build, shiftin=1 -> q=1101 and shiftout=1.
- Random load/data/en/shiftin for 1000 cycles -> q matches a reference model under the priority list.
- Other cases:
  - rst_n=0 with load=1 -> q=0000.
  - Without the macro, aset pulse shorter than a clk period and between edges -> no effect.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared constants and helpers for the shift register primitive.
// Direction names are compared against the SHIFT_DIRECTION parameter at
// elaboration, and the truncation helper trims preset values to the register width.
package shift_pkg;

    localparam string DIR_LEFT  = "LEFT";
    localparam string DIR_RIGHT = "RIGHT";

    // Keep only the low 'width' bits of a preset value; wider registers keep everything.
    function automatic logic [31:0] trunc_load(input logic [31:0] value, input int width);
        logic [31:0] mask_s;
        if (width >= 32) begin
            mask_s = 32'hFFFF_FFFF;
        end else begin
            mask_s = (32'd1 << width) - 32'd1;
        end
        return value & mask_s;
    endfunction

endpackage

// File: rtl/shift.sv
// Parameterizable shift register with parallel load, synchronous set/clear,
// top-priority set/clear (aset/aclr) and serial in/out.
// Build option: define SHIFT_ASYNC_CTRL_EN to make aclr/aset act asynchronously.
// Without it, aclr/aset are sampled at the clock edge like every other control.
module shift
    import shift_pkg::*;
#(
    parameter int    SHIFT_WIDTH     = 4,
    parameter string SHIFT_DIRECTION = "LEFT",
    parameter int    LOAD_AVALUE     = 11,
    parameter int    LOAD_SVALUE     = 14
) (
    input  logic                   sclr,
    input  logic                   sset,
    input  logic                   shiftin,
    input  logic                   load,
    input  logic [SHIFT_WIDTH-1:0] data,
    input  logic                   clk,
    input  logic                   en,
    input  logic                   aclr,
    input  logic                   aset,
    output logic                   shiftout,
    output logic [SHIFT_WIDTH-1:0] q,
    input  logic                   rst_n
);

    localparam bit IS_LEFT  = (SHIFT_DIRECTION == DIR_LEFT);
    localparam bit IS_RIGHT = (SHIFT_DIRECTION == DIR_RIGHT);

    localparam logic [SHIFT_WIDTH-1:0] AVAL =
        SHIFT_WIDTH'(trunc_load(32'(LOAD_AVALUE), SHIFT_WIDTH));
    localparam logic [SHIFT_WIDTH-1:0] SVAL =
        SHIFT_WIDTH'(trunc_load(32'(LOAD_SVALUE), SHIFT_WIDTH));

    // Reject unsupported parameterizations at elaboration time.
    generate
        if (!(IS_LEFT || IS_RIGHT)) begin : g_bad_direction
            $error("shift: SHIFT_DIRECTION must be \"LEFT\" or \"RIGHT\"");
        end
        if (SHIFT_WIDTH < 2) begin : g_bad_width
            $error("shift: SHIFT_WIDTH must be at least 2");
        end
    endgenerate

    logic [SHIFT_WIDTH-1:0] q_d;
    logic [SHIFT_WIDTH-1:0] q_q;

    // Next-state mux resolving every control strictly by priority.
    always_comb begin
        q_d = q_q;
        if (aclr) begin
            q_d = {SHIFT_WIDTH{1'b0}};
        end else if (aset) begin
            q_d = AVAL;
        end else if (!rst_n) begin
            q_d = {SHIFT_WIDTH{1'b0}};
        end else if (sclr) begin
            q_d = {SHIFT_WIDTH{1'b0}};
        end else if (sset) begin
            q_d = SVAL;
        end else if (load) begin
            q_d = data;
        end else if (en) begin
            if (IS_LEFT) begin
                q_d = {q_q[SHIFT_WIDTH-2:0], shiftin};
            end else begin
                q_d = {shiftin, q_q[SHIFT_WIDTH-1:1]};
            end
        end else begin
            q_d = q_q;
        end
    end

`ifdef SHIFT_ASYNC_CTRL_EN
    // Register with aclr/aset forcing the contents immediately, clock or not.
    always_ff @(posedge clk or posedge aclr or posedge aset) begin
        if (aclr) begin
            q_q <= {SHIFT_WIDTH{1'b0}};
        end else if (aset) begin
            q_q <= AVAL;
        end else begin
            q_q <= q_d;
        end
    end
`else
    // Fully synchronous register; aclr/aset/rst_n are already folded into q_d.
    always_ff @(posedge clk) begin
        if (!rst_n && !aclr && !aset) begin
            q_q <= {SHIFT_WIDTH{1'b0}};
        end else begin
            q_q <= q_d;
        end
    end
`endif

    assign q        = q_q;
    assign shiftout = IS_LEFT ? q_q[SHIFT_WIDTH-1] : q_q[0];

endmodule

// File: tb/tb_shift.sv
// Directed + random bench for shift: a LEFT and a RIGHT instance share stimulus;
// expected values come from a bench-side priority model and travel through a queue.
module tb_shift;

    localparam logic [3:0] AV = 4'd11;
    localparam logic [3:0] SV = 4'd14;

    logic       clk = 1'b0;
    logic       rst_n, aclr, aset, sclr, sset, load, en, shiftin;
    logic [3:0] data;
    logic [3:0] q_l, q_r;
    logic       so_l, so_r;

    typedef struct packed {
        logic [3:0] ql;
        logic       sol;
        logic [3:0] qr;
        logic       sor;
    } exp_t;

    exp_t       sb_q[$];
    logic [3:0] ml = 4'd0;
    logic [3:0] mr = 4'd0;
    int         n_checks = 0;
    int         n_fail   = 0;

    always #5 clk = ~clk;

    shift #(.SHIFT_WIDTH(4), .SHIFT_DIRECTION("LEFT"), .LOAD_AVALUE(11), .LOAD_SVALUE(14)) u_left (
        .sclr(sclr), .sset(sset), .shiftin(shiftin), .load(load), .data(data), .clk(clk),
        .en(en), .aclr(aclr), .aset(aset), .shiftout(so_l), .q(q_l), .rst_n(rst_n)
    );

    shift #(.SHIFT_WIDTH(4), .SHIFT_DIRECTION("RIGHT"), .LOAD_AVALUE(11), .LOAD_SVALUE(14)) u_right (
        .sclr(sclr), .sset(sset), .shiftin(shiftin), .load(load), .data(data), .clk(clk),
        .en(en), .aclr(aclr), .aset(aset), .shiftout(so_r), .q(q_r), .rst_n(rst_n)
    );

    function automatic logic [3:0] model_next(input logic [3:0] m, input bit left);
        if (aclr)        return 4'd0;
        else if (aset)   return AV;
        else if (!rst_n) return 4'd0;
        else if (sclr)   return 4'd0;
        else if (sset)   return SV;
        else if (load)   return data;
        else if (en)     return left ? {m[2:0], shiftin} : {shiftin, m[3:1]};
        else             return m;
    endfunction

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp_v);
        end
    endtask

    // Push the expectation for the current inputs, clock once, then pop and compare.
    task automatic step(input string tag);
        exp_t e;
        ml = model_next(ml, 1'b1);
        mr = model_next(mr, 1'b0);
        sb_q.push_back('{ql: ml, sol: ml[3], qr: mr, sor: mr[0]});
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        check({tag, ".q_left"},  q_l,          e.ql);
        check({tag, ".so_left"}, {3'd0, so_l}, {3'd0, e.sol});
        check({tag, ".q_right"}, q_r,          e.qr);
        check({tag, ".so_right"},{3'd0, so_r}, {3'd0, e.sor});
    endtask

    task automatic idle();
        rst_n = 1'b1; aclr = 1'b0; aset = 1'b0; sclr = 1'b0; sset = 1'b0;
        load = 1'b0; en = 1'b0; shiftin = 1'b0; data = 4'd0;
    endtask

    initial begin
        idle();
        #1;
        // Reset beats a simultaneous load.
        rst_n = 1'b0; load = 1'b1; data = 4'b0101;
        step("reset_with_load");
        idle();
        step("hold_after_reset");

        // aset presets, aclr wins over aset.
        aset = 1'b1;
        step("aset");
        aclr = 1'b1;
        step("aclr_over_aset");
        aclr = 1'b0;
        step("aset_again");
        aset = 1'b0; sclr = 1'b1;
        step("sclr");
        sclr = 1'b0; sset = 1'b1;
        step("sset");
        sset = 1'b0;

        // Parallel load with en low, data changing every cycle.
        load = 1'b1; data = 4'b0101;
        step("load_0101");
        data = 4'b1010;
        step("load_1010");
        data = 4'b0011;
        step("load_0011");
        load = 1'b0;
        step("hold");

        // Shifts from 1011 with shiftin 0 and 1.
        aset = 1'b1;
        step("preset_1011");
        aset = 1'b0; en = 1'b1; shiftin = 1'b0;
        step("shift_in0");
        aset = 1'b1; en = 1'b0;
        step("preset_1011b");
        aset = 1'b0; en = 1'b1; shiftin = 1'b1;
        step("shift_in1");
        step("shift_in1b");

        // Synchronous controls act regardless of en; reset discards a shift.
        sclr = 1'b1;
        step("sclr_with_en");
        sclr = 1'b0; sset = 1'b1;
        step("sset_with_en");
        sset = 1'b0; rst_n = 1'b0;
        step("reset_mid_shift");
        idle();

`ifdef SHIFT_ASYNC_CTRL_EN
        // Immediate clear between edges.
        aset = 1'b1;
        step("aset_async_pre");
        #2 aclr = 1'b1;
        #1 check("aclr_immediate", q_l, 4'd0);
        aclr = 1'b0; aset = 1'b0;
        ml = 4'd0; mr = 4'd0;
        step("after_async_clear");
`else
        // A short aset pulse between edges must leave q untouched.
        load = 1'b1; data = 4'b0110;
        step("glitch_setup");
        load = 1'b0;
        #2 aset = 1'b1;
        #2 aset = 1'b0;
        step("aset_glitch_ignored");
`endif

        // Random traffic against the priority model.
        for (int i = 0; i < 1000; i++) begin
            aclr    = ($urandom_range(0, 39) == 0);
            aset    = ($urandom_range(0, 39) == 0);
            rst_n   = ($urandom_range(0, 29) != 0);
            sclr    = ($urandom_range(0, 19) == 0);
            sset    = ($urandom_range(0, 19) == 0);
            load    = ($urandom_range(0, 4) == 0);
            en      = $urandom_range(0, 1) != 0;
            shiftin = $urandom_range(0, 1) != 0;
            data    = 4'($urandom_range(0, 15));
            step("random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
